fetch_queue: RTL

Instruction-fetch byte queue sitting directly upstream of the decoder in the core. It issues 64-byte line reads on the system bus, accepts 8-byte response beats, drops bytes before the fetch entry point, and stores the rest in a circular byte buffer. Each cycle it presents a 15-byte, left-aligned window to the decoder, which consumes 0–15 bytes per cycle. A redirect input flushes the queue and restarts fetch at a new address.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_byte_ram.sv | 33 +++
 rtl/fetch_queue.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch byte queue.
package fetch_pkg;
    localparam int LINE_BYTES     = 64;
    localparam int BEAT_BYTES     = 8;
    localparam int MAX_INST_BYTES = 15;

    typedef enum logic [1:0] {
        START,
        IDLE,
        WAITING,
        ACTIVE
    } fetch_state_t;

    // First beat lane at or above the entry offset (8 = whole beat below it)
    function automatic logic [3:0] first_kept(
        input logic [2:0] beat,
        input logic [5:0] skip
    );
        if (skip[5:3] > beat) return 4'd8;
        else if (skip[5:3] == beat) return {1'b0, skip[2:0]};
        else return 4'd0;
    endfunction
endpackage

// File: rtl/fetch_byte_ram.sv
// Circular byte store: 8-lane wrapping write, 15-byte wrapping read window.
module fetch_byte_ram
    import fetch_pkg::*;
#(
    parameter int BUF_BYTES = 128
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [BEAT_BYTES-1:0]           we,
    input  logic [$clog2(BUF_BYTES)-1:0]    wr_ptr,
    input  logic [8*BEAT_BYTES-1:0]         wdata,
    input  logic [$clog2(BUF_BYTES)-1:0]    rd_ptr,
    output logic [0:8*MAX_INST_BYTES-1]     rdata
);
    localparam int PW = $clog2(BUF_BYTES);

    logic [7:0] mem [BUF_BYTES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_BYTES; i++) mem[i] <= '0;
        end else begin
            for (int j = 0; j < BEAT_BYTES; j++)
                if (we[j]) mem[wr_ptr + PW'(j)] <= wdata[8*j +: 8];
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < MAX_INST_BYTES; k++)
            rdata[8*k +: 8] = mem[rd_ptr + PW'(k)];
    end
endmodule

// File: rtl/fetch_queue.sv
// Fetch byte queue feeding the decoder; line reads, skip, redirect flush.
// Define FETCHQ_ASSERT_EN to enable protocol/usage assertions.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int BUF_BYTES = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [63:0]                 entry,
    output logic                        req_cyc,
    output logic [63:0]                 req_addr,
    input  logic                        req_ack,
    input  logic                        resp_cyc,
    input  logic [63:0]                 resp,
    output logic                        resp_ack,
    input  logic                        redirect_valid,
    input  logic [63:0]                 redirect_rip,
    output logic [0:8*MAX_INST_BYTES-1] win_bytes,
    output logic [7:0]                  win_count,
    output logic                        win_valid,
    output logic [63:0]                 win_rip,
    input  logic [3:0]                  consume
);
    localparam int PW = $clog2(BUF_BYTES);

    fetch_state_t   state;
    logic [63:0]    fetch_line;
    logic [5:0]     skip;
    logic [2:0]     beat;
    logic           drop;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [7:0]     count;
    logic [63:0]    rip;

    logic           wr_en;
    logic           room;
    logic [3:0]     first;
    logic [3:0]     kept;
    logic [7:0]     we;
    logic [63:0]    wdata;

    // Kept bytes are packed down to lane 0 so they land contiguously
    always_comb begin
        first = first_kept(beat, skip);
        wr_en = (state == WAITING || state == ACTIVE) && resp_cyc
                && !drop && !redirect_valid;
        kept  = wr_en ? 4'd8 - first : 4'd0;
        we    = wr_en ? (8'hFF >> first) : 8'h00;
        wdata = resp >> {first, 3'b000};
        room  = count <= 8'(BUF_BYTES - LINE_BYTES);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= START;
            fetch_line <= '0;
            skip       <= '0;
            beat       <= '0;
            drop       <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rip        <= '0;
            req_cyc    <= 1'b0;
            req_addr   <= '0;
        end else if (state == START) begin
            state      <= IDLE;
            fetch_line <= {entry[63:6], 6'b0};
            skip       <= entry[5:0];
            rip        <= entry;
        end else begin
            case (state)
                IDLE: begin
                    if (req_cyc) begin
                        if (req_ack) begin
                            req_cyc <= 1'b0;
                            beat    <= '0;
                            state   <= WAITING;
                        end
                    end else if (room && !redirect_valid) begin
                        req_cyc  <= 1'b1;
                        req_addr <= fetch_line;
                    end
                end
                WAITING: begin
                    if (resp_cyc) begin
                        beat  <= beat + 3'd1;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (resp_cyc) begin
                        beat <= beat + 3'd1;
                    end else begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        if (!drop) begin
                            fetch_line <= fetch_line + 64'(LINE_BYTES);
                            skip       <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (redirect_valid) begin
                count      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                rip        <= redirect_rip;
                fetch_line <= {redirect_rip[63:6], 6'b0};
                skip       <= redirect_rip[5:0];
                if (req_cyc || state == WAITING || (state == ACTIVE && resp_cyc))
                    drop <= 1'b1;
            end else begin
                rd_ptr <= rd_ptr + PW'(consume);
                rip    <= rip + 64'(consume);
                wr_ptr <= wr_ptr + PW'(kept);
                count  <= count + 8'(kept) - 8'(consume);
            end
        end
    end

    assign resp_ack  = resp_cyc;
    assign win_count = count;
    assign win_valid = count >= 8'(MAX_INST_BYTES);
    assign win_rip   = rip;

    fetch_byte_ram #(
        .BUF_BYTES (BUF_BYTES)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wr_ptr (wr_ptr),
        .wdata  (wdata),
        .rd_ptr (rd_ptr),
        .rdata  (win_bytes)
    );

`ifdef FETCHQ_ASSERT_EN
    always @(posedge clk) begin
        if (reset && state != START) begin
            a_consume: assert (8'(consume) <= count)
                else $fatal(1, "consume exceeds win_count");
            a_valid: assert (!(consume != 0 && !win_valid && count >= 8'(MAX_INST_BYTES)))
                else $fatal(1, "window valid inconsistent with count");
            a_resp: assert (!(resp_cyc && state == IDLE))
                else $fatal(1, "response beat while idle");
            a_ack: assert (!(req_ack && !req_cyc))
                else $fatal(1, "req_ack without request");
            a_ovf: assert (32'(count) + 32'(kept) - 32'(consume) <= BUF_BYTES)
                else $fatal(1, "byte buffer overflow");
        end
        if (reset && state == START) begin
            a_resp_start: assert (!resp_cyc)
                else $fatal(1, "response beat in start");
        end
    end
`endif
endmodule
